// File: rtl/sync_pkg.sv
// Shared types and limits for the debounce block.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } debounce_state_t;

    localparam int DEBOUNCE_MAX = 255;

endpackage

// File: rtl/sync_event_latch.sv
// Sticky event flag: set wins over acknowledge in the same cycle.
module sync_event_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic ack,
    output logic flag
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set) begin
            flag_d = 1'b1;
        end else if (ack) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/sync_debounce.sv
// Debounces a synchronized level into a clean level plus rise/fall pulses.
// Define SYNC_DEBOUNCE_EVENT_LATCH_EN to add sticky rise/fall event flags.
module sync_debounce
    import sync_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    input  logic en,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
    ,
    input  logic evt_ack,
    output logic rise_evt,
    output logic fall_evt
`endif
);

    // Out-of-range settings are clamped rather than left to misbehave.
    localparam int N_EFF = (DEBOUNCE_CYCLES < 1) ? 1 :
                           (DEBOUNCE_CYCLES > DEBOUNCE_MAX) ? DEBOUNCE_MAX :
                           DEBOUNCE_CYCLES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_EFF - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    debounce_state_t  state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            count_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE_LOW: begin
                    if (sync_in) begin
                        if (N_EFF == 1) begin
                            state_d = IDLE_HIGH;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = CHK_HIGH;
                            count_d = ONE;
                        end
                    end
                end
                CHK_HIGH: begin
                    if (!sync_in) begin
                        state_d = IDLE_LOW;
                        count_d = '0;
                    end else if (count_q == LAST) begin
                        state_d = IDLE_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_in) begin
                        if (N_EFF == 1) begin
                            state_d = IDLE_LOW;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = CHK_LOW;
                            count_d = ONE;
                        end
                    end
                end
                CHK_LOW: begin
                    if (sync_in) begin
                        state_d = IDLE_HIGH;
                        count_d = '0;
                    end else if (count_q == LAST) begin
                        state_d = IDLE_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == CHK_HIGH) || (state_q == CHK_LOW);
        level      = level_q;
        rise_pulse = rise_q;
        fall_pulse = fall_q;
    end

`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
    sync_event_latch u_rise_evt (
        .clk  (clk),
        .rst  (rst),
        .set  (rise_q),
        .ack  (evt_ack),
        .flag (rise_evt)
    );

    sync_event_latch u_fall_evt (
        .clk  (clk),
        .rst  (rst),
        .set  (fall_q),
        .ack  (evt_ack),
        .flag (fall_evt)
    );
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: vector table, hand sequences, random vs model.
module tb_sync_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0 = 1'b0, e0 = 1'b1;
    logic s1 = 1'b0, e1 = 1'b1;
    logic lv0, r0, f0, b0;
    logic lv1, r1, f1, b1;
`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
    logic ack0 = 1'b0, ack1 = 1'b0;
    logic re0, fe0, re1, fe1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_debounce #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (s0),
        .en         (e0),
        .level      (lv0),
        .rise_pulse (r0),
        .fall_pulse (f0),
        .busy       (b0)
`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
        ,
        .evt_ack    (ack0),
        .rise_evt   (re0),
        .fall_evt   (fe0)
`endif
    );

    sync_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (s1),
        .en         (e1),
        .level      (lv1),
        .rise_pulse (r1),
        .fall_pulse (f1),
        .busy       (b1)
`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
        ,
        .evt_ack    (ack1),
        .rise_evt   (re1),
        .fall_evt   (fe1)
`endif
    );

    typedef struct {
        logic s;
        logic e;
        logic lv;
        logic r;
        logic f;
        logic b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic e, input logic lv,
                       input logic r, input logic f, input logic b,
                       input int rep);
        for (int i = 0; i < rep; i++) tbl.push_back('{s, e, lv, r, f, b});
    endtask

    task automatic check(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string nm, input logic lv, input logic r,
                        input logic f, input logic b);
        check({nm, ".level"}, lv0, lv);
        check({nm, ".rise"}, r0, r);
        check({nm, ".fall"}, f0, f);
        check({nm, ".busy"}, b0, b);
    endtask

    // Reference: a level change is accepted once N consecutive enabled
    // samples disagree with the current level; any agreeing sample restarts.
    int   m_n[2] = '{4, 1};
    int   m_run[2];
    logic m_lv[2];
    logic m_r[2];
    logic m_f[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0;
            m_lv[k]  = 1'b0;
            m_r[k]   = 1'b0;
            m_f[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input logic s, input logic e);
        for (int k = 0; k < 2; k++) begin
            m_r[k] = 1'b0;
            m_f[k] = 1'b0;
            if (e) begin
                if (s != m_lv[k]) begin
                    m_run[k]++;
                    if (m_run[k] == m_n[k]) begin
                        m_lv[k]  = s;
                        m_r[k]   = s;
                        m_f[k]   = ~s;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    endtask

    initial begin
        logic s, e, p;

        step();
        step();
        chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.n1.level", lv1, 1'b0);
        rst = 1'b0;

        add(1, 1, 0, 0, 0, 1, 3);
        add(1, 1, 1, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 2);
        add(0, 1, 1, 0, 0, 1, 3);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1, 3);
        add(0, 1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 1, 5);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 1, 1, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 3);
        add(1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 3);
        add(0, 1, 1, 0, 0, 1, 3);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            s0 = tbl[i].s;
            e0 = tbl[i].e;
            step();
            chk4($sformatf("vec%0d", i), tbl[i].lv, tbl[i].r,
                 tbl[i].f, tbl[i].b);
        end
        e0 = 1'b1;

        s0 = 1'b1;
        step();
        step();
        check("midrst.busy_before", b0, 1'b1);
        rst = 1'b1;
        #1;
        chk4("midrst.async", 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        s0  = 1'b0;
        step();
        chk4("midrst.after", 1'b0, 1'b0, 1'b0, 1'b0);
        s0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk4($sformatf("postrst.rise%0d", i), i == 3, i == 3, 1'b0, i < 3);
        end
        s0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk4($sformatf("postrst.fall%0d", i), i < 3, 1'b0, i == 3, i < 3);
        end

        p  = lv1;
        e1 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) s1 = ~s1;
            step();
            check($sformatf("n1.level%0d", i), lv1, s1);
            check($sformatf("n1.rise%0d", i), r1, s1 & ~p);
            check($sformatf("n1.fall%0d", i), f1, ~s1 & p);
            check($sformatf("n1.busy%0d", i), b1, 1'b0);
            p = s1;
        end

`ifdef SYNC_DEBOUNCE_EVENT_LATCH_EN
        s0 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("evt.rise_pulse", r0, 1'b1);
        ack0 = 1'b1;
        step();
        check("evt.rise_set_wins", re0, 1'b1);
        step();
        check("evt.rise_acked", re0, 1'b0);
        ack0 = 1'b0;
        s0   = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("evt.fall_pulse", f0, 1'b1);
        step();
        check("evt.fall_set", fe0, 1'b1);
        check("evt.rise_clear", re0, 1'b0);
        ack0 = 1'b1;
        step();
        check("evt.fall_acked", fe0, 1'b0);
        ack0 = 1'b0;
`endif

        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        s = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            e  = ($urandom_range(0, 7) != 0);
            s0 = s;
            s1 = s;
            e0 = e;
            e1 = e;
            step();
            model_edge(s, e);
            check($sformatf("rnd%0d.n4.level", i), lv0, m_lv[0]);
            check($sformatf("rnd%0d.n4.rise", i), r0, m_r[0]);
            check($sformatf("rnd%0d.n4.fall", i), f0, m_f[0]);
            check($sformatf("rnd%0d.n4.busy", i), b0, m_run[0] > 0);
            check($sformatf("rnd%0d.n1.level", i), lv1, m_lv[1]);
            check($sformatf("rnd%0d.n1.rise", i), r1, m_r[1]);
            check($sformatf("rnd%0d.n1.fall", i), f1, m_f[1]);
            check($sformatf("rnd%0d.n1.busy", i), b1, m_run[1] > 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Consumes the single-bit output of the reset-low two-flop synchronizer. Debounces that output with a consecutive-sample counter and a 4-state FSM. Produces a clean registered level plus one-cycle rise and fall pulses for downstream control logic, such as the AES start/abort command path. The input is already synchronous to clk, so no further metastability handling is done here.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a level change (legal range 1..255).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sync_in  input  1  synchronized level from the synchronizer stage
en  input  1  debounce enable; when 0 the FSM and counter hold
level  output  1  debounced level, registered
rise_pulse  output  1  one-cycle pulse on accepted 0->1 change
fall_pulse  output  1  one-cycle pulse on accepted 1->0 change
busy  output  1  1 while in a CHK state, combinational from state

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE_LOW, count=0.
  - level=0, rise_pulse=0, fall_pulse=0, busy=0.
  - Reset mid-check aborts the check with no pulse.
- FSM states: IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
- IDLE_LOW:
  - sync_in=1 and N>1 -> CHK_HIGH, count<=1.
  - sync_in=1 and N=1 -> IDLE_HIGH, level<=1, rise_pulse<=1.
  - Otherwise hold.
- CHK_HIGH:
  - sync_in=0 -> IDLE_LOW, count<=0, no pulse (glitch rejected).
  - sync_in=1 and count==N-1 -> IDLE_HIGH, level<=1, rise_pulse<=1, count<=0.
  - Otherwise count<=count+1.
- IDLE_HIGH and CHK_LOW: mirror of the above with polarities swapped; fall_pulse replaces rise_pulse.
- Acceptance timing: sync_in first sampled at edge k and held through edge k+N-1 -> level and the pulse are visible after edge k+N-1.
- Pulses: high exactly one cycle, otherwise 0. rise_pulse and fall_pulse are never high together.
- en=0: state, count and level hold; pulses forced 0 on the next edge. The count resumes on en=1; it is not cleared.
- Counter never exceeds N-1, so it never wraps.
- A toggle back at sample N-1 restarts the idle state; it does not extend the count.

Optional Feature:
SYNC_DEBOUNCE_EVENT_LATCH_EN
- Defined:
  - Adds input evt_ack (1) and outputs rise_evt (1) and fall_evt (1).
  - Each event flag sets on its pulse and clears on evt_ack=1.
  - Set and ack in the same cycle -> set wins (flag stays 1).
  - Flags reset to 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package sync_pkg:
  - typedef enum logic [1:0] debounce_state_t {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW}.
  - Constant DEBOUNCE_MAX=255 for parameter range checking.
- Sub-module sync_event_latch (one sticky flag with set/ack priority) for the optional feature, instantiated twice.
- Core FSM and counter stay in sync_debounce.

Test Plan:
- Reset, N=4: drive rst=1 mid-CHK_HIGH with count=2 -> all outputs 0 immediately; state IDLE_LOW after release.
- Clean rise, N=4: sync_in 0->1 held 6 cycles -> rise_pulse high one cycle after the 4th sampling edge, level=1 thereafter, busy high 3 cycles.
- Glitch, N=4: sync_in=1 for 3 cycles then 0 -> no pulse, level stays 0, state back to IDLE_LOW.
- en gating, N=4: sync_in=1 for 2 cycles, en=0 for 5 cycles, en=1 -> rise_pulse after 2 further sampled edges.
- N=1: sync_in toggles every 3 cycles -> level follows with 1-cycle latency, alternating rise/fall pulses.
- Event latch (macro defined): rise_pulse in the same cycle as evt_ack=1 -> rise_evt=1; a later evt_ack alone -> rise_evt=0.
